music_player_dp: RTL
====================

# music_player_dp

Datapath responder for the music playback sequencer. It consumes the sequencer's strobes (address advance/clear, tone-PWM enable/clear, beat-counter enable/clear) and returns `addr_finish` and `beat_finish`. It also fetches note words from an external synchronous song ROM, times each note's duration in beat units, and generates the square-wave buzzer output. It sits between the sequencer FSM, the song ROM and the board buzzer pin.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency; used at elaboration to build the half-period table.
- `BEAT_CYCLES`, 12_500_000, clock cycles per beat unit (0.25 s at 50 MHz).
- `ADDR_W`, 6, song ROM address width.
- `SONG_LEN`, 32, number of notes in the song; 1 ≤ `SONG_LEN` ≤ 2^`ADDR_W`.

Ports:
- `clk`  in  1  system clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `addr_en`  in  1  advance note pointer; single-cycle strobe.
- `addr_rstn`  in  1  synchronous clear of pointer and note register, active-low.
- `tune_pwm_en`  in  1  tone generator count enable.
- `tune_pwm_rstn`  in  1  synchronous clear of tone counter and buzzer, active-low.
- `beat_cnt_en`  in  1  duration counter enable.
- `beat_cnt_rstn`  in  1  synchronous clear of duration counter, active-low.
- `rom_addr`  out  `ADDR_W`  song ROM address.
- `rom_data`  in  8  note word, valid 1 cycle after `rom_addr`: [7:4] tone index, [3:0] duration in beats.
- `addr_finish`  out  1  song exhausted; level.
- `beat_finish`  out  1  current note duration elapsed; 1-cycle pulse.
- `buzzer`  out  1  square-wave audio output.

## Operation
- Reset: every output is 0. Pointer `ptr` = 0, `started` = 0, note register = 0, all counters = 0.
- `ptr` is `ADDR_W+1` bits wide.
  - `addr_rstn` = 0 → `ptr` = 0, `started` = 0, note = 0.
  - Otherwise, on `addr_en`: if `!started`, set `started` = 1 and hold `ptr` at 0. Else `ptr` += 1, saturating at `SONG_LEN`.
- `rom_addr` = `ptr` when `ptr` < `SONG_LEN`, else 0.
- `addr_finish` = (`ptr` == `SONG_LEN`), combinational from `ptr`.
- Note load: `addr_en` sets `load_pend`. In the next cycle, `note` ← `rom_data`, `load_pend` clears, and the beat and tone counters clear.
  - A load is suppressed when `addr_finish` is high; `note` keeps its last value.
- Duration: `dur` = `note[3:0]`; `dur` = 0 is treated as 1.
  - `beat_cnt` increments when `beat_cnt_en && !load_pend`.
  - `beat_cnt` width is clog2(15·`BEAT_CYCLES`+1).
  - When `beat_cnt` == `dur`·`BEAT_CYCLES`−1, `beat_finish` pulses for 1 cycle and `beat_cnt` holds until cleared.
  - `beat_cnt_rstn` = 0 overrides the enable.
- Tone table: `half[i]` = `CLK_HZ`/(2·f_i), integer division at elaboration. Frequencies in Hz:
  - i = 1..7: 262, 294, 330, 349, 392, 440, 494
  - i = 8..14: 523, 587, 659, 698, 784, 880, 988
  - i = 15: 1047
- Tone index 0 is a rest: `buzzer` is held at 0 and the tone counter is idle.
- Tone generator: while `tune_pwm_en && !load_pend` and tone ≠ 0, `tone_cnt` increments. At `half[tone]`−1 it wraps to 0 and `buzzer` toggles.
- `tune_pwm_rstn` = 0 → `tone_cnt` = 0 and `buzzer` = 0.
- Simultaneous events:
  - A clear input beats its matching enable.
  - `addr_rstn` beats `addr_en`.
  - A load cycle beats counting.

## Timing
- `addr_en` at cycle t → `rom_addr` updates at t+1 → `note` loaded at t+2. Counting starts at t+2 at the earliest.
- `beat_finish` is registered and rises on the clock edge after the terminal count.
- `addr_finish` follows `ptr` in the same cycle. The sequencer samples it in its advance state, one cycle after the `addr_en` that saturated `ptr`.
- Asserting `rstn` mid-note clears all state immediately. After `rstn` deasserts, nothing plays until an `addr_rstn` low and then `addr_en`.

## Configuration
- `MUSIC_DP_ARTIC_EN` defined: articulation gap. `buzzer` is forced to 0 while `beat_cnt` ≥ `dur`·`BEAT_CYCLES` − `BEAT_CYCLES`/8. The tone counter keeps running; the forcing is an output gate only.
- `MUSIC_DP_ARTIC_EN` undefined: `buzzer` is driven for the whole duration, so consecutive identical notes sound legato.

## Test plan
All scenarios use `CLK_HZ` = 88_000, `BEAT_CYCLES` = 1000, `SONG_LEN` = 4, with the macro off unless stated.
- Reset then `addr_rstn` low for 1 cycle, then `addr_en` pulse → `rom_addr` = 0 and `note` = `rom_data`[0] two cycles after the pulse; `addr_finish` = 0.
- Note 0x63 (A4, 3 beats) with all enables high → `buzzer` toggles every 100 cycles; `beat_finish` pulses once, exactly 3000 cycles after the load cycle.
- Note 0x02 (rest, 2 beats) → `buzzer` stays 0 throughout; `beat_finish` pulses after 2000 cycles.
- Five `addr_en` pulses → `rom_addr` sequence 0, 1, 2, 3; after the 5th pulse `addr_finish` = 1, `rom_addr` = 0, and `note` is unchanged.
- `rstn` pulsed low at cycle 500 of a note → `buzzer`, `beat_finish`, `rom_addr` and `addr_finish` all read 0 in the same cycle; no `beat_finish` follows.
- With `MUSIC_DP_ARTIC_EN` defined, note 0x61 → `buzzer` = 0 for cycles 875–999 of the note; it toggles normally before cycle 875.

Source files
------------

// File: rtl/music_player_dp.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// music_player_dp
// Datapath responder for the music playback sequencer. Walks a note pointer
// through an external song ROM, latches each note word, times the note
// duration in beat units and drives a square-wave buzzer at the note's pitch.
//
// Ports
//   clk            system clock
//   rstn           asynchronous active-low reset
//   addr_en        advance note pointer (1-cycle strobe)
//   addr_rstn      sync clear of pointer / started flag / note register
//   tune_pwm_en    tone counter enable
//   tune_pwm_rstn  sync clear of tone counter and buzzer
//   beat_cnt_en    duration counter enable
//   beat_cnt_rstn  sync clear of duration counter
//   rom_addr       song ROM address
//   rom_data       note word {tone[3:0], beats[3:0]}
//   addr_finish    song exhausted (level)
//   beat_finish    note duration elapsed (1-cycle pulse)
//   buzzer         square-wave audio output
//
// Build option: define MUSIC_DP_ARTIC_EN to silence the last eighth of a beat
// of every note (articulation gap between repeated notes).
// -----------------------------------------------------------------------------
module music_player_dp #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int ADDR_W      = 6,
    parameter int SONG_LEN    = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              addr_en,
    input  logic              addr_rstn,
    input  logic              tune_pwm_en,
    input  logic              tune_pwm_rstn,
    input  logic              beat_cnt_en,
    input  logic              beat_cnt_rstn,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              addr_finish,
    output logic              beat_finish,
    output logic              buzzer
);

    localparam int BEAT_W   = $clog2(15 * BEAT_CYCLES + 1);
    localparam int HALF_MAX = CLK_HZ / (2 * 262);
    localparam int TONE_W   = $clog2(HALF_MAX + 1);
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(SONG_LEN);

    // Half period in clock cycles for each tone index; index 0 (rest) is unused.
    function automatic int half_period(input logic [3:0] idx);
        int f;
        case (idx)
            4'd1:    f = 262;
            4'd2:    f = 294;
            4'd3:    f = 330;
            4'd4:    f = 349;
            4'd5:    f = 392;
            4'd6:    f = 440;
            4'd7:    f = 494;
            4'd8:    f = 523;
            4'd9:    f = 587;
            4'd10:   f = 659;
            4'd11:   f = 698;
            4'd12:   f = 784;
            4'd13:   f = 880;
            4'd14:   f = 988;
            4'd15:   f = 1047;
            default: f = 0;
        endcase
        return (f == 0) ? 1 : CLK_HZ / (2 * f);
    endfunction

    // Pointer advance saturating at SONG_LEN (the "exhausted" position).
    function automatic logic [ADDR_W:0] ptr_advance(input logic [ADDR_W:0] p);
        return (p < LAST) ? p + (ADDR_W+1)'(1) : p;
    endfunction

    logic [ADDR_W:0]   ptr;
    logic              started;
    logic              load_pend;
    logic [7:0]        note;
    logic [BEAT_W-1:0] beat_cnt;
    logic              beat_done;
    logic [TONE_W-1:0] tone_cnt;
    logic              buzz_q;

    logic              load;
    logic [3:0]        tone;
    logic [3:0]        dur;
    logic [BEAT_W-1:0] beat_len;
    logic [BEAT_W-1:0] beat_last;
    logic [TONE_W-1:0] tone_last;

    assign addr_finish = (ptr == LAST);
    assign rom_addr    = (ptr < LAST) ? ptr[ADDR_W-1:0] : '0;
    // Once the song is exhausted the pending load is dropped so the last note survives.
    assign load        = load_pend && addr_rstn && !addr_finish;
    assign tone        = note[7:4];
    assign dur         = (note[3:0] == 4'd0) ? 4'd1 : note[3:0];
    assign beat_len    = BEAT_W'(dur) * BEAT_W'(BEAT_CYCLES);
    assign beat_last   = beat_len - BEAT_W'(1);
    assign tone_last   = TONE_W'(half_period(tone) - 1);

    // Note pointer and note register. The first advance after a clear only
    // arms playback so that ROM entry 0 is fetched.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr       <= '0;
            started   <= 1'b0;
            note      <= '0;
            load_pend <= 1'b0;
        end else if (!addr_rstn) begin
            ptr       <= '0;
            started   <= 1'b0;
            note      <= '0;
            load_pend <= 1'b0;
        end else begin
            load_pend <= addr_en;
            if (addr_en) begin
                if (!started) started <= 1'b1;
                else          ptr     <= ptr_advance(ptr);
            end
            if (load) note <= rom_data;
        end
    end

    // Duration counter: stops at the terminal count and reports it once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt    <= '0;
            beat_done   <= 1'b0;
            beat_finish <= 1'b0;
        end else if (!beat_cnt_rstn || load) begin
            beat_cnt    <= '0;
            beat_done   <= 1'b0;
            beat_finish <= 1'b0;
        end else if (beat_cnt_en && !load_pend) begin
            if (beat_cnt >= beat_last) begin
                beat_finish <= !beat_done;
                beat_done   <= 1'b1;
            end else begin
                beat_cnt    <= beat_cnt + BEAT_W'(1);
                beat_finish <= 1'b0;
            end
        end else begin
            beat_finish <= 1'b0;
        end
    end

    // Tone generator: toggles the buzzer every half period; a rest holds it low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tone_cnt <= '0;
            buzz_q   <= 1'b0;
        end else if (!tune_pwm_rstn || load || tone == 4'd0) begin
            tone_cnt <= '0;
            buzz_q   <= 1'b0;
        end else if (tune_pwm_en && !load_pend) begin
            if (tone_cnt >= tone_last) begin
                tone_cnt <= '0;
                buzz_q   <= ~buzz_q;
            end else begin
                tone_cnt <= tone_cnt + TONE_W'(1);
            end
        end
    end

`ifdef MUSIC_DP_ARTIC_EN
    // Output gate only: the tone counter keeps its phase through the gap.
    assign buzzer = buzz_q && (beat_cnt < beat_len - BEAT_W'(BEAT_CYCLES / 8));
`else
    assign buzzer = buzz_q;
`endif

endmodule
